// File: rtl/fp_div_seq.sv
// fp_div_seq: multi-cycle IEEE-754 single-precision divider, Result = a_in / b_in.
// Restoring radix-2 mantissa division retiring one quotient bit per clock,
// with a start/done handshake. Denormal operands and results flush to zero.
// Optional feature: define FP_DIV_ROUND_NEAREST_EN to get round-to-nearest-even;
// without it the quotient is truncated and the latency is the same.
module fp_div_seq #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int BIAS  = 127
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [EXP_W+MAN_W:0] a_in,
    input  logic [EXP_W+MAN_W:0] b_in,
    output logic                 busy,
    output logic                 done,
    output logic [EXP_W+MAN_W:0] Result,
    output logic                 overflow,
    output logic                 underflow,
    output logic                 div_zero
);
    localparam int W  = EXP_W + MAN_W + 1;
    localparam int QW = MAN_W + 3;          // int, fraction, guard, extra bit
    localparam int CW = $clog2(QW);
    localparam int XW = EXP_W + 2;          // signed working exponent
    localparam logic signed [XW-1:0] BIAS_X   = XW'(BIAS);
    localparam logic signed [XW-1:0] EMAX_X   = XW'((1 << EXP_W) - 1);
    localparam logic signed [XW-1:0] ONE_X    = XW'(1);
    localparam logic [CW-1:0]        CNT_LAST = CW'(QW - 1);
    localparam logic [EXP_W-1:0]     EXP_ONES = '1;
    localparam logic [EXP_W-1:0]     EXP_ZERO = '0;
    localparam logic [W-1:0]         QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_DIV, S_NORM, S_PACK} state_t;

    state_t                  r_state;
    logic [CW-1:0]           r_cnt;
    logic                    r_special;
    logic                    r_hold;
    logic                    r_sign;
    logic signed [XW-1:0]    r_exp;
    logic [MAN_W+1:0]        r_rem;
    logic [MAN_W:0]          r_div;
    logic [QW-1:0]           r_q;
    logic [MAN_W-1:0]        r_mant;
    logic [W-1:0]            r_spec_res;
    logic                    r_spec_ovf;
    logic                    r_spec_dz;
`ifdef FP_DIV_ROUND_NEAREST_EN
    logic                    r_g;
    logic                    r_s;
`endif

    logic [EXP_W-1:0]        w_a_exp, w_b_exp;
    logic [MAN_W-1:0]        w_a_man, w_b_man;
    logic                    w_sign;
    logic signed [XW-1:0]    w_exp_init;
    logic                    w_special;
    logic [W-1:0]            w_spec_res;
    logic                    w_spec_ovf;
    logic                    w_spec_dz;
    logic [MAN_W+1:0]        w_div_ext;
    logic                    w_qbit;
    logic [MAN_W+1:0]        w_rem_sub;
    logic [MAN_W+1:0]        w_rem_next;
    logic [MAN_W-1:0]        w_norm_mant;
    logic signed [XW-1:0]    w_norm_exp;
`ifdef FP_DIV_ROUND_NEAREST_EN
    logic                    w_norm_g;
    logic                    w_norm_s;
    logic [MAN_W:0]          w_mant_rnd;
`endif
    logic [MAN_W-1:0]        w_mant_fin;
    logic signed [XW-1:0]    w_exp_fin;
    logic [W-1:0]            w_pack_res;
    logic                    w_pack_ovf;
    logic                    w_pack_unf;

`ifdef FP_DIV_ROUND_NEAREST_EN
    // Round-to-nearest-even increment decision
    function automatic logic round_inc(input logic g, input logic s, input logic lsb);
        return g & (s | lsb);
    endfunction
`endif

    assign w_a_exp    = a_in[W-2:MAN_W];
    assign w_b_exp    = b_in[W-2:MAN_W];
    assign w_a_man    = a_in[MAN_W-1:0];
    assign w_b_man    = b_in[MAN_W-1:0];
    assign w_sign     = a_in[W-1] ^ b_in[W-1];
    assign w_exp_init = $signed({2'b00, w_a_exp}) - $signed({2'b00, w_b_exp}) + BIAS_X;

    // Special-operand classification, evaluated on the start cycle in priority order
    always_comb begin
        w_special  = 1'b1;
        w_spec_res = '0;
        w_spec_ovf = 1'b0;
        w_spec_dz  = 1'b0;
        if (w_a_exp == EXP_ONES || w_b_exp == EXP_ONES) begin
            w_spec_res = QNAN;
            w_spec_ovf = 1'b1;
        end else if (w_b_exp == EXP_ZERO && w_a_exp == EXP_ZERO) begin
            w_spec_res = QNAN;
            w_spec_dz  = 1'b1;
        end else if (w_b_exp == EXP_ZERO) begin
            w_spec_res = {w_sign, EXP_ONES, {MAN_W{1'b0}}};
            w_spec_dz  = 1'b1;
        end else if (w_a_exp == EXP_ZERO) begin
            w_spec_res = {w_sign, {(W-1){1'b0}}};
        end else begin
            w_special  = 1'b0;
        end
    end

    // One restoring step: the partial remainder always stays below twice the divisor
    always_comb begin
        w_div_ext  = {1'b0, r_div};
        w_qbit     = (r_rem >= w_div_ext);
        w_rem_sub  = w_qbit ? (r_rem - w_div_ext) : r_rem;
        w_rem_next = {w_rem_sub[MAN_W:0], 1'b0};
    end

    // Normalise: quotient lies in (0.5, 2), so at most one left shift is needed
    always_comb begin
        if (r_q[QW-1]) begin
            w_norm_mant = r_q[QW-2:2];
            w_norm_exp  = r_exp;
        end else begin
            w_norm_mant = r_q[QW-3:1];
            w_norm_exp  = r_exp - ONE_X;
        end
`ifdef FP_DIV_ROUND_NEAREST_EN
        w_norm_g = r_q[QW-1] ? r_q[1] : r_q[0];
        w_norm_s = r_q[QW-1] ? (r_q[0] | (|r_rem)) : (|r_rem);
`endif
    end

    // Round (optional), then range-check the exponent and pack the word
    always_comb begin
`ifdef FP_DIV_ROUND_NEAREST_EN
        w_mant_rnd = {1'b0, r_mant} + {{MAN_W{1'b0}}, round_inc(r_g, r_s, r_mant[0])};
        w_mant_fin = w_mant_rnd[MAN_W-1:0];
        w_exp_fin  = w_mant_rnd[MAN_W] ? (r_exp + ONE_X) : r_exp;
`else
        w_mant_fin = r_mant;
        w_exp_fin  = r_exp;
`endif
        w_pack_ovf = 1'b0;
        w_pack_unf = 1'b0;
        if (w_exp_fin >= EMAX_X) begin
            w_pack_res = {r_sign, EXP_ONES, {MAN_W{1'b0}}};
            w_pack_ovf = 1'b1;
        end else if (w_exp_fin <= $signed({XW{1'b0}})) begin
            w_pack_res = {r_sign, {(W-1){1'b0}}};
            w_pack_unf = 1'b1;
        end else begin
            w_pack_res = {r_sign, w_exp_fin[EXP_W-1:0], w_mant_fin};
        end
    end

    // Datapath registers: operand latch, division steps, normalisation
    always_ff @(posedge clk) begin
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    r_sign     <= w_sign;
                    r_exp      <= w_exp_init;
                    r_rem      <= {1'b0, 1'b1, w_a_man};
                    r_div      <= {1'b1, w_b_man};
                    r_q        <= '0;
                    r_spec_res <= w_spec_res;
                    r_spec_ovf <= w_spec_ovf;
                    r_spec_dz  <= w_spec_dz;
                end
            end
            S_DIV: begin
                r_rem <= w_rem_next;
                r_q   <= {r_q[QW-2:0], w_qbit};
            end
            S_NORM: begin
                r_mant <= w_norm_mant;
                r_exp  <= w_norm_exp;
`ifdef FP_DIV_ROUND_NEAREST_EN
                r_g    <= w_norm_g;
                r_s    <= w_norm_s;
`endif
            end
            default: ;
        endcase
    end

    // Control FSM with registered handshake, result and flag outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_special <= 1'b0;
            r_hold    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            Result    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            div_zero  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        busy      <= 1'b1;
                        overflow  <= 1'b0;
                        underflow <= 1'b0;
                        div_zero  <= 1'b0;
                        r_cnt     <= '0;
                        r_hold    <= 1'b0;
                        r_special <= w_special;
                        r_state   <= w_special ? S_PACK : S_DIV;
                    end
                end
                S_DIV: begin
                    if (r_cnt == CNT_LAST) begin
                        r_cnt   <= '0;
                        r_state <= S_NORM;
                    end else begin
                        r_cnt   <= r_cnt + 1'b1;
                    end
                end
                S_NORM: r_state <= S_PACK;
                S_PACK: begin
                    // Special results wait one extra cycle so they complete two edges after start
                    if (r_special && !r_hold) begin
                        r_hold <= 1'b1;
                    end else begin
                        if (r_special) begin
                            Result   <= r_spec_res;
                            overflow <= r_spec_ovf;
                            div_zero <= r_spec_dz;
                        end else begin
                            Result    <= w_pack_res;
                            overflow  <= w_pack_ovf;
                            underflow <= w_pack_unf;
                        end
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_div_seq.sv
// tb_fp_div_seq: directed-vector bench for fp_div_seq with hand-computed results.
module tb_fp_div_seq;
    localparam int LIMIT = 60;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        busy;
    logic        done;
    logic [31:0] Result;
    logic        overflow;
    logic        underflow;
    logic        div_zero;

    int n_vec  = 0;
    int n_miss = 0;

    fp_div_seq dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .a_in      (a_in),
        .b_in      (b_in),
        .busy      (busy),
        .done      (done),
        .Result    (Result),
        .overflow  (overflow),
        .underflow (underflow),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Launch an op from the current cycle; optionally poke start or assert reset mid-op.
    // Returns the number of edges after the start-sampling edge until done was seen.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input int poke_at, input int rst_at, output int lat);
        logic rst_now;
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", {31'b0, busy}, 32'd1);
        lat = 0;
        rst_now = 1'b0;
        while (!done && lat < LIMIT) begin
            if (lat == poke_at) begin
                a_in  = 32'h3F800000;
                b_in  = 32'h3F800000;
                start = 1'b1;
            end
            if (lat == rst_at) begin
                reset   = 1'b1;
                rst_now = 1'b1;
            end
            @(posedge clk); #1;
            start = 1'b0;
            lat++;
            if (rst_now) begin
                reset = 1'b0;
                break;
            end
        end
    endtask

    task automatic do_vec(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input logic [2:0] exp_flags,
                          input int exp_lat);
        int lat;
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, {31'b0, done}, 32'd0);
        run_op(a, b, -1, -1, lat);
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_res"}, Result, exp_res);
        chk({tag, "_flags"}, {29'b0, overflow, underflow, div_zero}, {29'b0, exp_flags});
        chk({tag, "_busy_low"}, {31'b0, busy}, 32'd0);
    endtask

    initial begin
        int lat;
        int dones;
        reset = 1'b1;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",   {31'b0, busy}, 32'd0);
        chk("rst_done",   {31'b0, done}, 32'd0);
        chk("rst_result", Result, 32'h0);
        chk("rst_flags",  {29'b0, overflow, underflow, div_zero}, 32'd0);
        reset = 1'b0;

        // flags encoded {overflow, underflow, div_zero}
        do_vec("6div2",    32'h40C00000, 32'h40000000, 32'h40400000, 3'b000, 28);
`ifdef FP_DIV_ROUND_NEAREST_EN
        do_vec("1div3",    32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 3'b000, 28);
`else
        do_vec("1div3",    32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 3'b000, 28);
`endif
        do_vec("neg7p5",   32'hC0F00000, 32'h40200000, 32'hC0400000, 3'b000, 28);
        do_vec("2div2",    32'h40000000, 32'h40000000, 32'h3F800000, 3'b000, 28);
        do_vec("1div0",    32'h3F800000, 32'h00000000, 32'h7F800000, 3'b001, 2);
        do_vec("1divneg0", 32'h3F800000, 32'h80000000, 32'hFF800000, 3'b001, 2);
        do_vec("0div0",    32'h00000000, 32'h00000000, 32'h7FC00000, 3'b001, 2);
        do_vec("neg0div2", 32'h80000000, 32'h40000000, 32'h80000000, 3'b000, 2);
        do_vec("ovf",      32'h7F000000, 32'h00800000, 32'h7F800000, 3'b100, 28);
        do_vec("unf",      32'h00800000, 32'h7F000000, 32'h00000000, 3'b010, 28);
        do_vec("infdiv",   32'h7F800000, 32'h40000000, 32'h7FC00000, 3'b100, 2);
        do_vec("divnan",   32'h3F800000, 32'h7FC00000, 32'h7FC00000, 3'b100, 2);

        // start while busy is ignored
        @(posedge clk); #1;
        run_op(32'h40C00000, 32'h40000000, 10, -1, lat);
        chk("poke_lat", lat, 28);
        chk("poke_res", Result, 32'h40400000);

        // start in the done cycle is accepted; back-to-back results
        run_op(32'hC0F00000, 32'h40200000, -1, -1, lat);
        chk("b2b_lat", lat, 28);
        chk("b2b_res", Result, 32'hC0400000);
        chk("b2b_flags", {29'b0, overflow, underflow, div_zero}, 32'd0);

        // reset mid-op aborts without a done pulse
        @(posedge clk); #1;
        run_op(32'h40000000, 32'h40000000, -1, 15, lat);
        chk("abort_lat", lat, 16);
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_done", {31'b0, done}, 32'd0);
        chk("abort_result", Result, 32'h0);
        dones = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        chk("abort_no_done", dones, 0);
        do_vec("after_rst", 32'h40C00000, 32'h40000000, 32'h40400000, 3'b000, 28);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
